// File: rtl/idma_pkg.sv
// Shared defaults and helpers for the multi-channel iDMA dispatch front stage.
package idma_pkg;

    localparam int unsigned NumChanDef        = 4;
    localparam int unsigned ReqWidthDef       = 128;
    localparam int unsigned RspWidthDef       = 40;
    localparam int unsigned NumOutstandingDef = 8;
    localparam int unsigned MaxChan           = 32;

    // One-hot channel vector; callers size-cast the result down to their channel count.
    function automatic logic [MaxChan-1:0] chan_onehot(input int unsigned idx);
        logic [MaxChan-1:0] oh;
        oh = MaxChan'(1) << idx;
        return oh;
    endfunction

endpackage

// File: rtl/idma_dispatch_order_fifo.sv
// Order FIFO remembering which channel issued each in-flight backend request.
module idma_dispatch_order_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PtrW:0]      wr_ptr_reg;
    logic [PtrW:0]      rd_ptr_reg;
    logic [Width-1:0]   mem [Depth];

    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[PtrW] != rd_ptr_reg[PtrW]) &&
                     (wr_ptr_reg[PtrW-1:0] == rd_ptr_reg[PtrW-1:0]);
    assign data_o  = mem[rd_ptr_reg[PtrW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem[wr_ptr_reg[PtrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/idma_obi_nchan_dispatch.sv
// Round-robin multiplexer of NumChan iDMA frontends onto one OBI backend, with
// in-order response routing back to the issuing channel.
module idma_obi_nchan_dispatch
    import idma_pkg::*;
#(
    parameter int unsigned NumChan        = NumChanDef,
    parameter int unsigned ReqWidth       = ReqWidthDef,
    parameter int unsigned RspWidth       = RspWidthDef,
    parameter int unsigned NumOutstanding = NumOutstandingDef,
    parameter int unsigned ChanIdxWidth   = $clog2(NumChan),
    parameter int unsigned CntWidth       = $clog2(NumOutstanding + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumChan*ReqWidth-1:0]  chan_req_i,
    input  logic [NumChan-1:0]           chan_req_valid_i,
    output logic [NumChan-1:0]           chan_req_ready_o,
    output logic [RspWidth-1:0]          chan_rsp_o,
    output logic [NumChan-1:0]           chan_rsp_valid_o,
    input  logic [NumChan-1:0]           chan_rsp_ready_i,
    output logic [ReqWidth-1:0]          be_req_o,
    output logic                         be_req_valid_o,
    input  logic                         be_req_ready_i,
    input  logic [RspWidth-1:0]          be_rsp_i,
    input  logic                         be_rsp_valid_i,
    output logic                         be_rsp_ready_o,
    output logic [NumChan*CntWidth-1:0]  chan_outstanding_o,
    output logic                         busy_o,
    output logic                         err_o
);

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ChanIdxWidth-1:0] head_idx;
    logic [ChanIdxWidth-1:0] winner;
    logic [ChanIdxWidth-1:0] rr_ptr_reg;
    logic [ChanIdxWidth-1:0] lock_idx_reg;
    logic                    lock_reg;
    logic                    err_reg;
    logic                    win_valid;
    logic                    req_hs;
    logic                    rsp_hs;
    logic [NumChan-1:0]      win_oh;
    logic [NumChan-1:0]      head_oh;

    // Scan downwards so the last hit is the channel closest to the RR pointer.
    always_comb begin
        winner    = rr_ptr_reg;
        win_valid = 1'b0;
        if (lock_reg) begin
            winner    = lock_idx_reg;
            win_valid = chan_req_valid_i[lock_idx_reg];
        end else begin
            for (int i = NumChan - 1; i >= 0; i--) begin
                if (chan_req_valid_i[(int'(rr_ptr_reg) + i) % NumChan]) begin
                    winner    = ChanIdxWidth'((int'(rr_ptr_reg) + i) % NumChan);
                    win_valid = 1'b1;
                end
            end
        end
    end

    // Reset gates the combinational handshakes so nothing is offered while state is being cleared.
    assign be_req_valid_o   = win_valid & ~fifo_full & ~rst_i;
    assign be_req_o         = chan_req_i[32'(winner)*ReqWidth +: ReqWidth];
    assign win_oh           = NumChan'(chan_onehot(32'(winner)));
    assign chan_req_ready_o = {NumChan{be_req_valid_o & be_req_ready_i}} & win_oh;
    assign req_hs           = be_req_valid_o & be_req_ready_i;

    assign head_oh          = NumChan'(chan_onehot(32'(head_idx)));
    assign chan_rsp_valid_o = (be_rsp_valid_i & ~fifo_empty) ? head_oh : '0;
    assign be_rsp_ready_o   = ~fifo_empty & chan_rsp_ready_i[head_idx];
    assign chan_rsp_o       = be_rsp_i;
    assign rsp_hs           = be_rsp_valid_i & be_rsp_ready_o;

    assign busy_o = ~fifo_empty;
    assign err_o  = err_reg;

    idma_dispatch_order_fifo #(
        .Depth (NumOutstanding),
        .Width (ChanIdxWidth)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_hs),
        .data_i  (winner),
        .pop_i   (rsp_hs),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            lock_reg     <= be_req_valid_o & ~be_req_ready_i;
            lock_idx_reg <= winner;
            if (req_hs) begin
                rr_ptr_reg <= (winner == ChanIdxWidth'(NumChan - 1)) ? '0 : winner + 1'b1;
            end
            if (be_rsp_valid_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NumChan; gi++) begin : g_cnt
        logic                inc;
        logic                dec;
        logic [CntWidth-1:0] cnt_reg;

        assign inc = req_hs && (winner == ChanIdxWidth'(gi));
        assign dec = rsp_hs && (head_idx == ChanIdxWidth'(gi));
        assign chan_outstanding_o[gi*CntWidth +: CntWidth] = cnt_reg;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
            end else if (inc && !dec) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (dec && !inc) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idma_obi_nchan_dispatch.sv
// Bench for idma_obi_nchan_dispatch: arbitration table, order scoreboard and hand-written corner sequences.
module tb_idma_obi_nchan_dispatch;

    localparam int NC = 4;
    localparam int RW = 128;
    localparam int SW = 40;
    localparam int NO = 8;
    localparam int IW = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*RW-1:0]  chan_req;
    logic [NC-1:0]     chan_req_valid;
    logic [NC-1:0]     chan_req_ready;
    logic [SW-1:0]     chan_rsp;
    logic [NC-1:0]     chan_rsp_valid;
    logic [NC-1:0]     chan_rsp_ready;
    logic [RW-1:0]     be_req;
    logic              be_req_valid;
    logic              be_req_ready;
    logic [SW-1:0]     be_rsp;
    logic              be_rsp_valid;
    logic              be_rsp_ready;
    logic [NC*CW-1:0]  outstanding;
    logic              busy;
    logic              err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    idma_obi_nchan_dispatch #(
        .NumChan        (NC),
        .ReqWidth       (RW),
        .RspWidth       (SW),
        .NumOutstanding (NO),
        .ChanIdxWidth   (IW),
        .CntWidth       (CW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .chan_req_i         (chan_req),
        .chan_req_valid_i   (chan_req_valid),
        .chan_req_ready_o   (chan_req_ready),
        .chan_rsp_o         (chan_rsp),
        .chan_rsp_valid_o   (chan_rsp_valid),
        .chan_rsp_ready_i   (chan_rsp_ready),
        .be_req_o           (be_req),
        .be_req_valid_o     (be_req_valid),
        .be_req_ready_i     (be_req_ready),
        .be_rsp_i           (be_rsp),
        .be_rsp_valid_i     (be_rsp_valid),
        .be_rsp_ready_o     (be_rsp_ready),
        .chan_outstanding_o (outstanding),
        .busy_o             (busy),
        .err_o              (err)
    );

    function automatic logic [RW-1:0] pay(input int c);
        return {4{24'hA5C3E1, 8'(c)}};
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // A stalled request must keep valid and payload until it is accepted.
    logic          stall_q = 1'b0;
    logic [RW-1:0] stall_req;
    always @(negedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) check("lock_hold", {be_req_valid, be_req}, {1'b1, stall_req});
            stall_q   <= be_req_valid & ~be_req_ready;
            stall_req <= be_req;
        end
    end

    typedef struct {
        logic [NC-1:0] valid;
        logic          ready;
        logic          exp_valid;
        int            exp_win;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int e;
        vecs[0] = '{4'b1111, 1'b1, 1'b1, 0};
        vecs[1] = '{4'b1111, 1'b1, 1'b1, 1};
        vecs[2] = '{4'b1111, 1'b1, 1'b1, 2};
        vecs[3] = '{4'b1111, 1'b1, 1'b1, 3};
        vecs[4] = '{4'b1111, 1'b1, 1'b1, 0};
        vecs[5] = '{4'b0101, 1'b1, 1'b1, 2};
        vecs[6] = '{4'b0101, 1'b1, 1'b1, 0};
        vecs[7] = '{4'b1000, 1'b0, 1'b1, 3};
        vecs[8] = '{4'b1001, 1'b1, 1'b1, 3};
        vecs[9] = '{4'b0001, 1'b1, 1'b0, 0};

        for (int c = 0; c < NC; c++) chan_req[c*RW +: RW] = pay(c);
        rst            = 1'b1;
        chan_req_valid = 4'b1111;
        chan_rsp_ready = 4'b1111;
        be_req_ready   = 1'b1;
        be_rsp_valid   = 1'b0;
        be_rsp         = '0;
        tick();
        tick();

        // Reset state with requests pending
        check("rst_req_valid", be_req_valid, 1'b0);
        check("rst_req_ready", chan_req_ready, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_outstanding", outstanding, 16'h0000);
        check("rst_rsp_valid", chan_rsp_valid, 4'b0000);
        rst = 1'b0;

        // Arbitration table: fairness, lock, full FIFO
        for (int i = 0; i < 10; i++) begin
            chan_req_valid = vecs[i].valid;
            be_req_ready   = vecs[i].ready;
            #1;
            $display("vec %0d valid=%b be_ready=%b grant=%b", i, chan_req_valid, be_req_ready, chan_req_ready);
            check("arb_valid", be_req_valid, vecs[i].exp_valid);
            check("arb_ready", chan_req_ready,
                  vecs[i].exp_valid ? ({NC{vecs[i].ready}} & (4'b0001 << vecs[i].exp_win)) : 4'b0000);
            if (vecs[i].exp_valid) check("arb_payload", be_req, pay(vecs[i].exp_win));
            if (vecs[i].exp_valid && vecs[i].ready) exp_q.push_back(vecs[i].exp_win);
            tick();
        end
        check("arb_counters", outstanding, 16'h2213);
        check("arb_busy", busy, 1'b1);

        // Full FIFO: a pop does not free a slot for a push in the same cycle
        chan_req_valid = 4'b0001;
        be_rsp_valid   = 1'b1;
        be_rsp         = 40'h00_0000_0011;
        #1;
        e = exp_q.pop_front();
        check("full_same_cycle_ready", chan_req_ready, 4'b0000);
        check("full_pop_ready", be_rsp_ready, 1'b1);
        check("full_pop_route", chan_rsp_valid, 4'b0001 << e);
        tick();
        be_rsp_valid = 1'b0;
        #1;
        check("full_next_cycle_ready", chan_req_ready, 4'b0001);
        exp_q.push_back(0);
        tick();
        chan_req_valid = 4'b0000;

        // Drain in order
        for (int i = 0; i < NO; i++) begin
            be_rsp_valid = 1'b1;
            be_rsp       = 40'h00_0000_0100 + 40'(i);
            #1;
            e = exp_q.pop_front();
            $display("rsp %0d -> ch%0d valid=%b", i, e, chan_rsp_valid);
            check("drain_route", chan_rsp_valid, 4'b0001 << e);
            check("drain_payload", chan_rsp, 40'h00_0000_0100 + 40'(i));
            check("drain_ready", be_rsp_ready, 1'b1);
            tick();
        end
        be_rsp_valid = 1'b0;
        #1;
        check("drain_busy", busy, 1'b0);
        check("drain_counters", outstanding, 16'h0000);
        check("drain_err", err, 1'b0);

        // Routing ch1, ch3, ch1 with backpressure on ch3
        do_reset();
        foreach (exp_q[k]) exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            e = (i == 1) ? 3 : 1;
            chan_req_valid = 4'b0001 << e;
            #1;
            $display("issue ch%0d grant=%b", e, chan_req_ready);
            check("route_issue", chan_req_ready, 4'b0001 << e);
            exp_q.push_back(e);
            tick();
        end
        chan_req_valid = 4'b0000;
        check("route_counters", outstanding, 16'h1020);
        be_rsp_valid = 1'b1;
        be_rsp       = 40'hAA_0000_0001;
        #1;
        e = exp_q.pop_front();
        check("route_rsp1", chan_rsp_valid, 4'b0001 << e);
        check("route_rsp1_ready", be_rsp_ready, 1'b1);
        tick();
        chan_rsp_ready = 4'b0111;
        #1;
        check("route_rsp2_valid", chan_rsp_valid, 4'b0001 << exp_q[0]);
        check("route_rsp2_blocked", be_rsp_ready, 1'b0);
        tick();
        check("route_rsp2_held", chan_rsp_valid, 4'b1000);
        check("route_rsp2_still_blocked", be_rsp_ready, 1'b0);
        check("route_held_counters", outstanding, 16'h1010);
        chan_rsp_ready = 4'b1111;
        #1;
        e = exp_q.pop_front();
        check("route_rsp2", chan_rsp_valid, 4'b0001 << e);
        check("route_rsp2_ready", be_rsp_ready, 1'b1);
        tick();
        #1;
        e = exp_q.pop_front();
        check("route_rsp3", chan_rsp_valid, 4'b0001 << e);
        tick();
        be_rsp_valid = 1'b0;
        #1;
        check("route_busy", busy, 1'b0);

        // Lock: ch2 stalled while ch0 requests
        do_reset();
        chan_req_valid = 4'b0100;
        be_req_ready   = 1'b0;
        #1;
        check("lock_first", be_req, pay(2));
        tick();
        chan_req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_payload", be_req, pay(2));
            check("lock_no_ready", chan_req_ready, 4'b0000);
            tick();
        end
        be_req_ready = 1'b1;
        #1;
        check("lock_release", chan_req_ready, 4'b0100);
        tick();
        chan_req_valid = 4'b0001;
        #1;
        check("lock_next_grant", chan_req_ready, 4'b0001);
        tick();
        chan_req_valid = 4'b0000;

        // Spurious response on an empty FIFO
        do_reset();
        be_rsp_valid = 1'b1;
        #1;
        check("spur_ready", be_rsp_ready, 1'b0);
        check("spur_rsp_valid", chan_rsp_valid, 4'b0000);
        check("spur_err_before", err, 1'b0);
        tick();
        be_rsp_valid = 1'b0;
        #1;
        check("spur_err_set", err, 1'b1);
        tick();
        tick();
        check("spur_err_sticky", err, 1'b1);
        check("spur_counters", outstanding, 16'h0000);

        // Asynchronous reset mid-transfer
        chan_req_valid = 4'b1111;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_req_valid", be_req_valid, 1'b0);
        check("arst_req_ready", chan_req_ready, 4'b0000);
        check("arst_busy", busy, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_counters", outstanding, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        check("arst_first_grant", chan_req_ready, 4'b0001);
        check("arst_first_payload", be_req, pay(0));
        tick();
        chan_req_valid = 4'b0000;
        #1;
        check("arst_counter_after", outstanding, 16'h0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
